// File: rtl/sssp_pkg.sv
// Shared types for the SSSP write-back path.
// Holds the word and lane-bundle types, the lane count, the packer state
// enum and a helper that turns a word count into a contiguous lane mask.
package sssp_pkg;

  localparam int WORD_W = 64;
  localparam int LANES  = 4;

  typedef logic [WORD_W-1:0] word_t;
  typedef word_t [LANES-1:0] lane_words_t;

  typedef struct packed {
    logic [LANES-1:0] valid;
    lane_words_t      words;
  } bundle_t;

  typedef enum logic {
    FILL,
    FLUSH
  } pack_state_t;

  // n = 0..LANES; a shift by LANES clears everything, giving an all-ones mask
  function automatic logic [LANES-1:0] prefix_mask(input logic [2:0] n);
    return ~({LANES{1'b1}} << n);
  endfunction

endpackage

// File: rtl/line_packer_if.sv
// Handshake bundle between the lane filter, the line packer and write-back.
// Input side : word_in_valid, word_in, last_input_in, in_ready.
// Output side: line_out, line_out_mask, line_out_last, line_out_valid,
//              line_out_ready.
// master = the environment driving bundles and consuming lines,
// slave  = the line packer itself.
interface line_packer_if;
  import sssp_pkg::*;

  logic [LANES-1:0] word_in_valid;
  lane_words_t      word_in;
  logic             last_input_in;
  logic             in_ready;

  lane_words_t      line_out;
  logic [LANES-1:0] line_out_mask;
  logic             line_out_last;
  logic             line_out_valid;
  logic             line_out_ready;

  modport master (
    output word_in_valid, word_in, last_input_in, line_out_ready,
    input  in_ready, line_out, line_out_mask, line_out_last, line_out_valid
  );

  modport slave (
    input  word_in_valid, word_in, last_input_in, line_out_ready,
    output in_ready, line_out, line_out_mask, line_out_last, line_out_valid
  );

endinterface

// File: rtl/lane_compactor.sv
// Combinational lane compactor.
// bundle_in    : per-lane valid bits plus words.
// packed_words : valid words moved to the lowest lanes in ascending lane
//                order; unused upper lanes are zero.
// nvalid       : number of valid lanes (0..LANES).
module lane_compactor
  import sssp_pkg::*;
(
  input  bundle_t     bundle_in,
  output lane_words_t packed_words,
  output logic [2:0]  nvalid
);

  logic [2:0] slot;

  always_comb begin
    packed_words = '0;
    slot         = '0;
    for (int l = 0; l < LANES; l++) begin
      if (bundle_in.valid[2'(l)]) begin
        packed_words[slot[1:0]] = bundle_in.words[2'(l)];
        slot                    = slot + 3'd1;
      end
    end
    nvalid = slot;
  end

endmodule

// File: rtl/line_packer.sv
// Line packer: appends the valid words of 4-lane bundles into a buffer and
// emits dense 4-word lines; on the final bundle it flushes the remainder as
// a partial line (prefix mask) flagged last.
// Ports:
//   clk - clock
//   rst - asynchronous active-high reset
//   bus - line_packer_if.slave (input bundle handshake + output line handshake)
// Parameter BUF_DEPTH: buffer entries, must be at least 2*LANES.
module line_packer
  import sssp_pkg::*;
#(
  parameter int BUF_DEPTH = 8
) (
  input  logic          clk,
  input  logic          rst,
  line_packer_if.slave  bus
);

  localparam int CNT_W  = $clog2(BUF_DEPTH + 1);
  localparam int BUF_W  = BUF_DEPTH * WORD_W;
  localparam int LINE_W = LANES * WORD_W;

  pack_state_t      state;
  logic [CNT_W-1:0] count;
  logic [BUF_W-1:0] buf_q;

  bundle_t          bundle;
  lane_words_t      packed_words;
  lane_words_t      push_words;
  logic [2:0]       nvalid;

  logic             accept;
  logic             can_load;
  logic             load;
  logic             last_next;
  logic [CNT_W-1:0] pop;
  logic [CNT_W-1:0] push;
  logic [CNT_W-1:0] surv;
  logic [CNT_W-1:0] count_next;
  logic [BUF_W-1:0] keep_mask;
  logic [BUF_W-1:0] buf_next;
  logic [LINE_W-1:0] line_next;

  assign bundle = '{valid: bus.word_in_valid, words: bus.word_in};

  lane_compactor u_compactor (
    .bundle_in    (bundle),
    .packed_words (packed_words),
    .nvalid       (nvalid)
  );

  // Room for a full bundle is guaranteed whenever in_ready is high
  assign bus.in_ready = !rst && (state == FILL) &&
                        (count <= CNT_W'(BUF_DEPTH - LANES));
  assign accept   = bus.in_ready;
  assign can_load = !bus.line_out_valid || bus.line_out_ready;

  always_comb begin
    load = 1'b0;
    pop  = '0;
    if (can_load) begin
      if (state == FILL && count >= CNT_W'(LANES)) begin
        load = 1'b1;
        pop  = CNT_W'(LANES);
      end else if (state == FLUSH) begin
        load = 1'b1;
        pop  = (count > CNT_W'(LANES)) ? CNT_W'(LANES) : count;
      end
    end
  end

  assign last_next  = (state == FLUSH) && (count <= CNT_W'(LANES));
  assign push       = accept ? CNT_W'(nvalid) : '0;
  assign push_words = accept ? packed_words : '0;
  assign surv       = count - pop;
  assign count_next = surv + push;

  // Entry 0 lives in the low bits. Popping shifts down; entries at or above
  // the surviving count may be stale and are masked before the new words
  // are ORed in behind the survivors.
  always_comb begin
    keep_mask = ~({BUF_W{1'b1}} << (int'(surv) * WORD_W));
    buf_next  = ((buf_q >> (int'(pop) * WORD_W)) & keep_mask) |
                (BUF_W'(push_words) << (int'(surv) * WORD_W));
  end

  // Lanes beyond the popped count are forced to zero on partial lines
  assign line_next = buf_q[LINE_W-1:0] & ~({LINE_W{1'b1}} << (int'(pop) * WORD_W));

  always_ff @(posedge clk) begin
    buf_q <= buf_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state              <= FILL;
      count              <= '0;
      bus.line_out_valid <= 1'b0;
      bus.line_out       <= '0;
      bus.line_out_mask  <= '0;
      bus.line_out_last  <= 1'b0;
    end else begin
      count <= count_next;
      if (load) begin
        bus.line_out_valid <= 1'b1;
        bus.line_out       <= line_next;
        bus.line_out_mask  <= prefix_mask(3'(pop));
        bus.line_out_last  <= last_next;
      end else if (bus.line_out_ready) begin
        bus.line_out_valid <= 1'b0;
      end
      if (accept && bus.last_input_in) begin
        state <= FLUSH;
      end else if (load && last_next) begin
        state <= FILL;
      end
    end
  end

endmodule

// File: tb/tb_line_packer.sv
// Self-checking bench for line_packer: a table of per-cycle vectors with
// hand-computed expected outputs, plus sequences for backpressure and
// asynchronous reset.
module tb_line_packer;
  import sssp_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  line_packer_if bus ();

  line_packer #(.BUF_DEPTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    bit               pre_reset;
    logic [3:0]       valid;
    lane_words_t      words;
    logic             last;
    logic             ready;
    logic             exp_valid;
    lane_words_t      exp_line;
    logic [3:0]       exp_mask;
    logic             exp_last;
    logic             exp_in_ready;
  } vec_t;

  vec_t vecs[$];

  // Backpressure scoreboard state
  int next_word;
  int exp_word;
  bit last_sent;
  bit seen_last;

  localparam int J = 'h0DEAD;

  function automatic lane_words_t w4(input int a, input int b, input int c, input int d);
    return {word_t'(d), word_t'(c), word_t'(b), word_t'(a)};
  endfunction

  function automatic vec_t mk(input bit pre, input logic [3:0] v, input lane_words_t w,
                              input logic last, input logic rdy, input logic ev,
                              input lane_words_t el, input logic [3:0] em,
                              input logic elast, input logic eir);
    vec_t r;
    r.pre_reset = pre;  r.valid = v;   r.words = w;    r.last = last;  r.ready = rdy;
    r.exp_valid = ev;   r.exp_line = el; r.exp_mask = em; r.exp_last = elast;
    r.exp_in_ready = eir;
    return r;
  endfunction

  task automatic check_val(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_idle();
    bus.word_in_valid = '0;
    bus.word_in       = '0;
    bus.last_input_in = 1'b0;
  endtask

  task automatic do_reset();
    set_idle();
    bus.line_out_ready = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic applyStimulus(input vec_t r);
    if (r.pre_reset) do_reset();
    @(negedge clk);
    bus.word_in_valid  = r.valid;
    bus.word_in        = r.words;
    bus.last_input_in  = r.last;
    bus.line_out_ready = r.ready;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input vec_t r, input int idx);
    check_val($sformatf("vec%0d line_out_valid", idx), bus.line_out_valid, r.exp_valid);
    check_val($sformatf("vec%0d in_ready", idx), bus.in_ready, r.exp_in_ready);
    if (r.exp_valid) begin
      check_val($sformatf("vec%0d line_out", idx), bus.line_out, r.exp_line);
      check_val($sformatf("vec%0d line_out_mask", idx), bus.line_out_mask, r.exp_mask);
      check_val($sformatf("vec%0d line_out_last", idx), bus.line_out_last, r.exp_last);
    end
  endtask

  // Called at a negedge where the current line will be taken on the next edge
  task automatic consume_line();
    logic [3:0] m;
    m = bus.line_out_mask;
    check_val("bp beat after last", seen_last, 1'b0);
    check_val("bp mask is prefix",
              (m == 4'b0000 || m == 4'b0001 || m == 4'b0011 || m == 4'b0111 || m == 4'b1111), 1'b1);
    for (int l = 0; l < 4; l++) begin
      if (m[l]) begin
        check_val($sformatf("bp word %0d", exp_word), bus.line_out[l], word_t'(exp_word));
        exp_word++;
      end else begin
        check_val("bp unused lane zero", bus.line_out[l], '0);
      end
    end
    if (bus.line_out_last) seen_last = 1'b1;
  endtask

  task automatic drive_cycle(input logic rdy, input bit send_data, input bit send_last);
    @(negedge clk);
    bus.line_out_ready = rdy;
    if (bus.line_out_valid && rdy) consume_line();
    set_idle();
    if (bus.in_ready) begin
      if (send_last) begin
        bus.last_input_in = 1'b1;
        last_sent = 1'b1;
      end else if (send_data) begin
        bus.word_in_valid = 4'hF;
        bus.word_in = w4(next_word, next_word + 1, next_word + 2, next_word + 3);
        next_word += 4;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    lane_words_t snap;
    set_idle();
    bus.line_out_ready = 1'b0;

    // Reset state while rst is held
    #1 rst = 1'b1;
    #2;
    check_val("reset line_out_valid", bus.line_out_valid, 1'b0);
    check_val("reset line_out", bus.line_out, '0);
    check_val("reset line_out_mask", bus.line_out_mask, '0);
    check_val("reset line_out_last", bus.line_out_last, 1'b0);
    check_val("reset in_ready", bus.in_ready, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Full bundles, words 1..12, ready high
    vecs.push_back(mk(0, 4'hF, w4(1, 2, 3, 4),    1'b0, 1'b1, 1'b0, '0,             4'h0, 1'b0, 1'b1));
    vecs.push_back(mk(0, 4'hF, w4(5, 6, 7, 8),    1'b0, 1'b1, 1'b1, w4(1, 2, 3, 4), 4'hF, 1'b0, 1'b1));
    vecs.push_back(mk(0, 4'hF, w4(9, 10, 11, 12), 1'b0, 1'b1, 1'b1, w4(5, 6, 7, 8), 4'hF, 1'b0, 1'b1));
    vecs.push_back(mk(0, 4'h0, '0,                1'b0, 1'b1, 1'b1, w4(9, 10, 11, 12), 4'hF, 1'b0, 1'b1));
    vecs.push_back(mk(0, 4'h0, '0,                1'b0, 1'b1, 1'b0, '0,             4'h0, 1'b0, 1'b1));
    // Sparse lanes then a last bundle carrying one word
    vecs.push_back(mk(0, 4'b1010, w4(J, 'hA1, J, 'hB2), 1'b0, 1'b1, 1'b0, '0, 4'h0, 1'b0, 1'b1));
    vecs.push_back(mk(0, 4'b0110, w4(J, 'hC3, 'hD4, J), 1'b0, 1'b1, 1'b0, '0, 4'h0, 1'b0, 1'b1));
    vecs.push_back(mk(0, 4'b0001, w4('hE5, J, J, J),    1'b1, 1'b1, 1'b1,
                      w4('hA1, 'hB2, 'hC3, 'hD4), 4'hF, 1'b0, 1'b0));
    vecs.push_back(mk(0, 4'h0, '0, 1'b0, 1'b1, 1'b1, w4('hE5, 0, 0, 0), 4'b0001, 1'b1, 1'b1));
    vecs.push_back(mk(0, 4'h0, '0, 1'b0, 1'b1, 1'b0, '0, 4'h0, 1'b0, 1'b1));
    // Exact multiple of 4: the last bundle arrives while line 1 is stalled
    vecs.push_back(mk(0, 4'hF, w4(1, 2, 3, 4), 1'b0, 1'b0, 1'b0, '0,             4'h0, 1'b0, 1'b1));
    vecs.push_back(mk(0, 4'hF, w4(5, 6, 7, 8), 1'b0, 1'b0, 1'b1, w4(1, 2, 3, 4), 4'hF, 1'b0, 1'b1));
    vecs.push_back(mk(0, 4'h0, '0,             1'b1, 1'b0, 1'b1, w4(1, 2, 3, 4), 4'hF, 1'b0, 1'b0));
    vecs.push_back(mk(0, 4'h0, '0,             1'b0, 1'b1, 1'b1, w4(5, 6, 7, 8), 4'hF, 1'b1, 1'b1));
    vecs.push_back(mk(0, 4'h0, '0,             1'b0, 1'b1, 1'b0, '0,             4'h0, 1'b0, 1'b1));
    vecs.push_back(mk(0, 4'h0, '0,             1'b0, 1'b1, 1'b0, '0,             4'h0, 1'b0, 1'b1));
    // Empty flush after reset: one mask=0000 last=1 beat
    vecs.push_back(mk(1, 4'h0, '0, 1'b1, 1'b1, 1'b0, '0, 4'h0, 1'b0, 1'b0));
    vecs.push_back(mk(0, 4'h0, '0, 1'b0, 1'b1, 1'b1, '0, 4'h0, 1'b1, 1'b1));
    vecs.push_back(mk(0, 4'h0, '0, 1'b0, 1'b1, 1'b0, '0, 4'h0, 1'b0, 1'b1));

    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      checkOutput(vecs[i], i);
    end

    // Backpressure: stall the output, overfill, then drain 20 words
    do_reset();
    next_word = 1;
    exp_word  = 1;
    last_sent = 1'b0;
    seen_last = 1'b0;
    repeat (3) drive_cycle(1'b0, 1'b1, 1'b0);
    snap = bus.line_out;
    check_val("bp first line", snap, w4(1, 2, 3, 4));
    check_val("bp stall valid", bus.line_out_valid, 1'b1);
    repeat (3) begin
      drive_cycle(1'b0, 1'b1, 1'b0);
      check_val("bp stable line", bus.line_out, snap);
      check_val("bp in_ready low", bus.in_ready, 1'b0);
    end
    check_val("bp accepted words", next_word, 13);
    for (int c = 0; c < 60 && !seen_last; c++) begin
      drive_cycle(1'b1, next_word <= 20, next_word > 20 && !last_sent);
    end
    check_val("bp last seen", seen_last, 1'b1);
    check_val("bp word count", exp_word, 21);
    repeat (2) drive_cycle(1'b1, 1'b0, 1'b0);

    // Asynchronous reset with count=3 and a line pending
    do_reset();
    @(negedge clk);
    bus.line_out_ready = 1'b0;
    bus.word_in_valid  = 4'hF;
    bus.word_in        = w4('h11, 'h12, 'h13, 'h14);
    @(negedge clk);
    bus.word_in_valid  = 4'b0111;
    bus.word_in        = w4('h15, 'h16, 'h17, 'hFF);
    @(negedge clk);
    set_idle();
    check_val("areset pre valid", bus.line_out_valid, 1'b1);
    #2 rst = 1'b1;
    #1;
    check_val("areset line_out_valid", bus.line_out_valid, 1'b0);
    check_val("areset line_out", bus.line_out, '0);
    check_val("areset line_out_mask", bus.line_out_mask, '0);
    check_val("areset line_out_last", bus.line_out_last, 1'b0);
    check_val("areset in_ready", bus.in_ready, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    bus.line_out_ready = 1'b1;
    bus.word_in_valid  = 4'hF;
    bus.word_in        = w4('h21, 'h22, 'h23, 'h24);
    @(negedge clk);
    set_idle();
    @(negedge clk);
    check_val("areset clean valid", bus.line_out_valid, 1'b1);
    check_val("areset clean line", bus.line_out, w4('h21, 'h22, 'h23, 'h24));
    check_val("areset clean mask", bus.line_out_mask, 4'hF);
    check_val("areset clean last", bus.line_out_last, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
